// File: rtl/tl_pkg.sv
// Shared types and helpers for the traffic-light lamp monitor.
package tl_pkg;

    // Decoded colour of one direction's lamp vector.
    // COL_NONE only exists as the "nothing seen yet" value after clear.
    typedef enum logic [2:0] {
        COL_NONE    = 3'd0,
        COL_RED     = 3'd1,
        COL_YELLOW  = 3'd2,
        COL_GREEN   = 3'd3,
        COL_ILLEGAL = 3'd4
    } colour_t;

    // Lamp vectors ordered {red, yellow, green}
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    // Exactly one lamp on maps to a colour; any other vector is illegal.
    function automatic colour_t decode_lamps(input logic [2:0] lamps);
        colour_t col;
        case (lamps)
            LAMP_RED:    col = COL_RED;
            LAMP_YELLOW: col = COL_YELLOW;
            LAMP_GREEN:  col = COL_GREEN;
            default:     col = COL_ILLEGAL;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/tl_lamp_tracker.sv
// Per-direction tracker: decodes the lamp vector, remembers the previous
// colour, counts segment dwell and reports per-sample violations as
// combinational strobes. The parent registers them.
module tl_lamp_tracker
    import tl_pkg::*;
#(
    parameter int GREEN_CYCLES  = 30,
    parameter int YELLOW_CYCLES = 5,
    parameter int DW_W          = 8
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    output logic [2:0] colour,
    output logic       illegal_code,
    output logic       bad_trans,
    output logic       bad_dwell,
    output logic       rise_to_green
);

    localparam logic [DW_W-1:0] GREEN_DW  = DW_W'(GREEN_CYCLES);
    localparam logic [DW_W-1:0] YELLOW_DW = DW_W'(YELLOW_CYCLES);
    localparam logic [DW_W-1:0] DW_MAX    = '1;

    colour_t         prev_reg, prev_next;
    logic [DW_W-1:0] dwell_reg, dwell_next;
    logic            armed_reg, armed_next;

    colour_t cur_col;
    logic    cur_illegal;
    logic    prev_legal;
    logic    legal_change;
    logic    legal_step;

    // State register: previous colour, dwell counter, armed bit
    always_ff @(posedge clk) begin
        if (clear) begin
            prev_reg  <= COL_NONE;
            dwell_reg <= '0;
            armed_reg <= 1'b0;
        end else begin
            prev_reg  <= prev_next;
            dwell_reg <= dwell_next;
            armed_reg <= armed_next;
        end
    end

    // Classify the current sample relative to the stored colour
    always_comb begin
        cur_col      = decode_lamps({red, yellow, green});
        cur_illegal  = (cur_col == COL_ILLEGAL);
        prev_legal   = (prev_reg == COL_RED) || (prev_reg == COL_YELLOW) ||
                       (prev_reg == COL_GREEN);
        // A change between two legal colours; NONE/ILLEGAL predecessors are exempt
        legal_change = !cur_illegal && prev_legal && (cur_col != prev_reg);
        legal_step   = ((prev_reg == COL_RED)    && (cur_col == COL_GREEN))  ||
                       ((prev_reg == COL_GREEN)  && (cur_col == COL_YELLOW)) ||
                       ((prev_reg == COL_YELLOW) && (cur_col == COL_RED));
    end

    // Next-state: dwell counts samples of the current colour, armed marks a
    // segment that began with a legal-to-legal change (so its length is trusted)
    always_comb begin
        prev_next  = cur_col;
        dwell_next = 1'b1;
        armed_next = armed_reg;
        if (cur_col == prev_reg) begin
            dwell_next = (dwell_reg == DW_MAX) ? dwell_reg : dwell_reg + 1'b1;
        end else begin
            dwell_next = DW_W'(1);
        end
        if (cur_illegal) begin
            armed_next = 1'b0;
        end else if (legal_change) begin
            armed_next = 1'b1;
        end
    end

    // Output strobes for the current sample
    always_comb begin
        colour        = cur_col;
        illegal_code  = cur_illegal;
        bad_trans     = legal_change && !legal_step;
        bad_dwell     = legal_change && armed_reg &&
                        (((prev_reg == COL_GREEN)  && (dwell_reg != GREEN_DW)) ||
                         ((prev_reg == COL_YELLOW) && (dwell_reg != YELLOW_DW)));
        rise_to_green = legal_change && (prev_reg == COL_RED) && (cur_col == COL_GREEN);
    end

endmodule

// File: rtl/tl_monitor.sv
// Passive protocol checker for the traffic-light controller's lamp outputs.
// Index 0 tracks the NS direction, index 1 the WE direction.
module tl_monitor
    import tl_pkg::*;
#(
    parameter int GREEN_CYCLES  = 30,
    parameter int YELLOW_CYCLES = 5,
    parameter int DW_W          = 8,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             RED_NS,
    input  logic             YELLOW_NS,
    input  logic             GREEN_NS,
    input  logic             RED_WE,
    input  logic             YELLOW_WE,
    input  logic             GREEN_WE,
    output logic             err_code,
    output logic             err_trans,
    output logic             err_dwell,
    output logic             err_conflict,
    output logic             err_any,
    output logic             cycle_done,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0] lamps      [2];
    logic [2:0] colour     [2];
    logic [1:0] illegal_code;
    logic [1:0] bad_trans;
    logic [1:0] bad_dwell;
    logic [1:0] rise_to_green;
    logic [1:0] is_go;

    logic             err_code_reg, err_trans_reg, err_dwell_reg, err_conflict_reg;
    logic             cycle_done_reg;
    logic [CNT_W-1:0] cycle_count_reg;

    assign lamps[0] = {RED_NS, YELLOW_NS, GREEN_NS};
    assign lamps[1] = {RED_WE, YELLOW_WE, GREEN_WE};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dir
            tl_lamp_tracker #(
                .GREEN_CYCLES  (GREEN_CYCLES),
                .YELLOW_CYCLES (YELLOW_CYCLES),
                .DW_W          (DW_W)
            ) u_tracker (
                .clk           (clk),
                .clear         (clear),
                .red           (lamps[gi][2]),
                .yellow        (lamps[gi][1]),
                .green         (lamps[gi][0]),
                .colour        (colour[gi]),
                .illegal_code  (illegal_code[gi]),
                .bad_trans     (bad_trans[gi]),
                .bad_dwell     (bad_dwell[gi]),
                .rise_to_green (rise_to_green[gi])
            );
            // Non-red means a decoded green or yellow; ILLEGAL is not counted
            assign is_go[gi] = (colour[gi] == COL_GREEN) || (colour[gi] == COL_YELLOW);
        end
    endgenerate

    // Sticky error flags and the NS cycle pulse/counter
    always_ff @(posedge clk) begin
        if (clear) begin
            err_code_reg     <= 1'b0;
            err_trans_reg    <= 1'b0;
            err_dwell_reg    <= 1'b0;
            err_conflict_reg <= 1'b0;
            cycle_done_reg   <= 1'b0;
            cycle_count_reg  <= '0;
        end else begin
            err_code_reg     <= err_code_reg     | (|illegal_code);
            err_trans_reg    <= err_trans_reg    | (|bad_trans);
            err_dwell_reg    <= err_dwell_reg    | (|bad_dwell);
            err_conflict_reg <= err_conflict_reg | (&is_go);
            cycle_done_reg   <= rise_to_green[0];
            if (rise_to_green[0] && (cycle_count_reg != CNT_MAX)) begin
                cycle_count_reg <= cycle_count_reg + 1'b1;
            end
        end
    end

    // Drive outputs from the registered state
    always_comb begin
        err_code     = err_code_reg;
        err_trans    = err_trans_reg;
        err_dwell    = err_dwell_reg;
        err_conflict = err_conflict_reg;
        err_any      = err_code_reg | err_trans_reg | err_dwell_reg | err_conflict_reg;
        cycle_done   = cycle_done_reg;
        cycle_count  = cycle_count_reg;
    end

endmodule

// File: tb/tb_tl_monitor.sv
// Self-checking bench for tl_monitor: per-cycle scoreboard of cycle_done /
// cycle_count plus scenario-specific flag checks.
module tb_tl_monitor;

    localparam int CNT_W = 16;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic             clk = 1'b0;
    logic             clear = 1'b1;
    logic [2:0]       ns_lamps = 3'b100;
    logic [2:0]       we_lamps = 3'b100;
    logic             err_code, err_trans, err_dwell, err_conflict, err_any;
    logic             cycle_done;
    logic [CNT_W-1:0] cycle_count;

    typedef struct {
        bit done;
        int count;
    } exp_t;

    exp_t exp_q[$];
    int   exp_count = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    tl_monitor #(
        .GREEN_CYCLES  (30),
        .YELLOW_CYCLES (5),
        .DW_W          (8),
        .CNT_W         (CNT_W)
    ) dut (
        .clk          (clk),
        .clear        (clear),
        .RED_NS       (ns_lamps[2]),
        .YELLOW_NS    (ns_lamps[1]),
        .GREEN_NS     (ns_lamps[0]),
        .RED_WE       (we_lamps[2]),
        .YELLOW_WE    (we_lamps[1]),
        .GREEN_WE     (we_lamps[0]),
        .err_code     (err_code),
        .err_trans    (err_trans),
        .err_dwell    (err_dwell),
        .err_conflict (err_conflict),
        .err_any      (err_any),
        .cycle_done   (cycle_done),
        .cycle_count  (cycle_count)
    );

    // One sample: drive lamps, push the expectation, pop and compare after the edge
    task automatic step(input logic [2:0] ns, input logic [2:0] we, input bit exp_done);
        exp_t e;
        clear    = 1'b0;
        ns_lamps = ns;
        we_lamps = we;
        if (exp_done && exp_count < 65535) exp_count++;
        e.done  = exp_done;
        e.count = exp_count;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        tests_run++;
        if (cycle_done !== e.done) begin
            tests_failed++;
            $display("FAIL cycle_done @%0t: got %b want %b", $time, cycle_done, e.done);
        end
        tests_run++;
        if (cycle_count !== 16'(e.count)) begin
            tests_failed++;
            $display("FAIL cycle_count @%0t: got %0d want %0d", $time, cycle_count, e.count);
        end
    endtask

    task automatic seg(input logic [2:0] ns, input logic [2:0] we, input int n, input bit first_done);
        for (int i = 0; i < n; i++) step(ns, we, first_done && (i == 0));
    endtask

    task automatic do_clear(input int n);
        clear     = 1'b1;
        exp_count = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_clear(2);
        tests_run++; if (err_code !== 1'b0)     begin tests_failed++; $display("FAIL rst_code: got %b want 0", err_code); end
        tests_run++; if (err_trans !== 1'b0)    begin tests_failed++; $display("FAIL rst_trans: got %b want 0", err_trans); end
        tests_run++; if (err_dwell !== 1'b0)    begin tests_failed++; $display("FAIL rst_dwell: got %b want 0", err_dwell); end
        tests_run++; if (err_conflict !== 1'b0) begin tests_failed++; $display("FAIL rst_conflict: got %b want 0", err_conflict); end
        tests_run++; if (err_any !== 1'b0)      begin tests_failed++; $display("FAIL rst_any: got %b want 0", err_any); end
        tests_run++; if (cycle_done !== 1'b0)   begin tests_failed++; $display("FAIL rst_done: got %b want 0", cycle_done); end
        tests_run++; if (cycle_count !== 16'd0) begin tests_failed++; $display("FAIL rst_count: got %0d want 0", cycle_count); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_legal_cycles();
        seg(R, R, 5, 1'b0);
        for (int c = 0; c < 3; c++) begin
            seg(G, R, 30, 1'b1);
            seg(Y, R, 5, 1'b0);
            seg(R, G, 30, 1'b0);
            seg(R, Y, 5, 1'b0);
            seg(R, R, 5, 1'b0);
        end
        tests_run++; if (err_any !== 1'b0)      begin tests_failed++; $display("FAIL t1_any: got %b want 0", err_any); end
        tests_run++; if (err_dwell !== 1'b0)    begin tests_failed++; $display("FAIL t1_dwell: got %b want 0", err_dwell); end
        tests_run++; if (err_trans !== 1'b0)    begin tests_failed++; $display("FAIL t1_trans: got %b want 0", err_trans); end
        tests_run++; if (err_conflict !== 1'b0) begin tests_failed++; $display("FAIL t1_conflict: got %b want 0", err_conflict); end
        tests_run++; if (cycle_count !== 16'd3) begin tests_failed++; $display("FAIL t1_count: got %0d want 3", cycle_count); end
        $display("[TB] test_legal_cycles done, cycle_count=%0d", cycle_count);
    endtask

    task automatic test_short_yellow();
        do_clear(1);
        seg(R, R, 3, 1'b0);
        seg(G, R, 30, 1'b1);
        seg(Y, R, 4, 1'b0);
        tests_run++; if (err_dwell !== 1'b0) begin tests_failed++; $display("FAIL t2_dwell_early: got %b want 0", err_dwell); end
        step(R, R, 1'b0);
        tests_run++; if (err_dwell !== 1'b1) begin tests_failed++; $display("FAIL t2_dwell: got %b want 1", err_dwell); end
        tests_run++; if (err_any !== 1'b1)   begin tests_failed++; $display("FAIL t2_any: got %b want 1", err_any); end
        tests_run++; if (err_trans !== 1'b0) begin tests_failed++; $display("FAIL t2_trans: got %b want 0", err_trans); end
        seg(R, R, 5, 1'b0);
        tests_run++; if (err_dwell !== 1'b1) begin tests_failed++; $display("FAIL t2_dwell_hold: got %b want 1", err_dwell); end
        tests_run++; if (err_any !== 1'b1)   begin tests_failed++; $display("FAIL t2_any_hold: got %b want 1", err_any); end
        $display("[TB] test_short_yellow done");
    endtask

    task automatic test_conflict();
        do_clear(1);
        step(G, Y, 1'b0);
        tests_run++; if (err_conflict !== 1'b1) begin tests_failed++; $display("FAIL t3_conflict: got %b want 1", err_conflict); end
        tests_run++; if (err_trans !== 1'b0)    begin tests_failed++; $display("FAIL t3_trans: got %b want 0", err_trans); end
        tests_run++; if (err_code !== 1'b0)     begin tests_failed++; $display("FAIL t3_code: got %b want 0", err_code); end
        tests_run++; if (err_dwell !== 1'b0)    begin tests_failed++; $display("FAIL t3_dwell: got %b want 0", err_dwell); end
        step(G, R, 1'b0);
        tests_run++; if (err_conflict !== 1'b1) begin tests_failed++; $display("FAIL t3_conflict_hold: got %b want 1", err_conflict); end
        tests_run++; if (err_trans !== 1'b0)    begin tests_failed++; $display("FAIL t3_trans_after: got %b want 0", err_trans); end
        $display("[TB] test_conflict done");
    endtask

    task automatic test_bad_transition();
        do_clear(1);
        seg(R, R, 2, 1'b0);
        seg(G, R, 3, 1'b1);
        tests_run++; if (err_trans !== 1'b0) begin tests_failed++; $display("FAIL t4_trans_early: got %b want 0", err_trans); end
        step(R, R, 1'b0);
        tests_run++; if (err_trans !== 1'b1) begin tests_failed++; $display("FAIL t4_trans: got %b want 1", err_trans); end
        step(G, R, 1'b1);
        tests_run++; if (err_trans !== 1'b1)    begin tests_failed++; $display("FAIL t4_trans_hold: got %b want 1", err_trans); end
        tests_run++; if (err_dwell !== 1'b1)    begin tests_failed++; $display("FAIL t4_dwell: got %b want 1", err_dwell); end
        tests_run++; if (err_code !== 1'b0)     begin tests_failed++; $display("FAIL t4_code: got %b want 0", err_code); end
        tests_run++; if (err_conflict !== 1'b0) begin tests_failed++; $display("FAIL t4_conflict: got %b want 0", err_conflict); end
        $display("[TB] test_bad_transition done");
    endtask

    task automatic test_illegal_code();
        do_clear(1);
        seg(R, R, 2, 1'b0);
        step(3'b110, R, 1'b0);
        tests_run++; if (err_code !== 1'b1)     begin tests_failed++; $display("FAIL t5_code: got %b want 1", err_code); end
        tests_run++; if (err_conflict !== 1'b0) begin tests_failed++; $display("FAIL t5_conflict: got %b want 0", err_conflict); end
        seg(G, R, 12, 1'b0);
        step(Y, R, 1'b0);
        tests_run++; if (err_dwell !== 1'b0) begin tests_failed++; $display("FAIL t5_dwell: got %b want 0", err_dwell); end
        tests_run++; if (err_trans !== 1'b0) begin tests_failed++; $display("FAIL t5_trans: got %b want 0", err_trans); end
        tests_run++; if (err_code !== 1'b1)  begin tests_failed++; $display("FAIL t5_code_hold: got %b want 1", err_code); end
        $display("[TB] test_illegal_code done");
    endtask

    task automatic test_mid_clear();
        do_clear(1);
        seg(R, R, 3, 1'b0);
        step(3'b000, R, 1'b0);
        seg(R, R, 2, 1'b0);
        seg(G, R, 5, 1'b1);
        tests_run++; if (err_code !== 1'b1)     begin tests_failed++; $display("FAIL t6_code_pre: got %b want 1", err_code); end
        tests_run++; if (cycle_count !== 16'd1) begin tests_failed++; $display("FAIL t6_count_pre: got %0d want 1", cycle_count); end
        do_clear(1);
        tests_run++; if (err_code !== 1'b0)     begin tests_failed++; $display("FAIL t6_code_clr: got %b want 0", err_code); end
        tests_run++; if (err_any !== 1'b0)      begin tests_failed++; $display("FAIL t6_any_clr: got %b want 0", err_any); end
        tests_run++; if (cycle_done !== 1'b0)   begin tests_failed++; $display("FAIL t6_done_clr: got %b want 0", cycle_done); end
        tests_run++; if (cycle_count !== 16'd0) begin tests_failed++; $display("FAIL t6_count_clr: got %0d want 0", cycle_count); end
        seg(G, R, 10, 1'b0);
        step(Y, R, 1'b0);
        tests_run++; if (err_dwell !== 1'b0) begin tests_failed++; $display("FAIL t6_dwell: got %b want 0", err_dwell); end
        tests_run++; if (err_any !== 1'b0)   begin tests_failed++; $display("FAIL t6_any: got %b want 0", err_any); end
        $display("[TB] test_mid_clear done");
    endtask

    initial begin
        test_reset();
        test_legal_cycles();
        test_short_yellow();
        test_conflict();
        test_bad_transition();
        test_illegal_code();
        test_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tl_monitor.md
Name: tl_monitor

Overview:
- Passive checker on the receiving end of the traffic-light controller's six lamp outputs (RED/YELLOW/GREEN for the NS and WE directions).
- Decodes each direction's lamp vector and tracks its colour sequence and dwell times.
- Flags illegal lamp codes, illegal transitions, wrong dwell lengths and conflicting greens.
- Sits beside the controller in the TLC subsystem and in benches as a bolt-on protocol checker. It drives no lamps.

Parameters:
- GREEN_CYCLES, 30: required green dwell per direction, in clk cycles.
- YELLOW_CYCLES, 5: required yellow dwell per direction, in clk cycles.
- DW_W, 8: dwell counter width. Must hold max(GREEN_CYCLES, YELLOW_CYCLES)+1.
- CNT_W, 16: width of the completed-cycle counter.

Ports:
- clk  in  1  system clock, rising edge
- clear  in  1  synchronous, active-high reset
- RED_NS, YELLOW_NS, GREEN_NS  in  1 each  NS lamp drives from the controller
- RED_WE, YELLOW_WE, GREEN_WE  in  1 each  WE lamp drives from the controller
- err_code  out  1  sticky: a direction showed a lamp vector other than exactly one lamp on
- err_trans  out  1  sticky: illegal colour transition
- err_dwell  out  1  sticky: green or yellow segment length differed from its parameter
- err_conflict  out  1  sticky: both directions non-red in the same sample
- err_any  out  1  OR of the four sticky flags (combinational from registered flags)
- cycle_done  out  1  one-cycle pulse on each NS red->green transition
- cycle_count  out  CNT_W  count of cycle_done pulses, saturating at all-ones

Behaviour:
- Only one clock domain. clear is synchronous and active-high and overrides everything.
- While clear=1, all outputs are 0, dwell counters are 0, prev colour = NONE, armed=0, and inputs are ignored.
- Decode per direction, {R,Y,G}: 100=RED, 010=YELLOW, 001=GREEN, anything else=ILLEGAL.
- Each rising edge compares the sampled colour against the stored prev colour. Flags and pulses register at that same edge, so they are visible one cycle after the offending value is presented.
- Legal transitions: RED->GREEN, GREEN->YELLOW, YELLOW->RED. Same colour means dwell counter +1, saturating at 2^DW_W-1.
- On a colour change, the dwell counter loads 1.
- Any other change between legal colours sets err_trans.
- Dwell check on exit, only when armed:
  - leaving GREEN with dwell != GREEN_CYCLES sets err_dwell;
  - leaving YELLOW with dwell != YELLOW_CYCLES sets err_dwell.
  - RED dwell is unchecked.
- Armed rule: after clear, or after an ILLEGAL sample, the first segment is partial. Its exit is not dwell-checked. armed sets at the first colour change between legal colours.
- The NONE->colour and ILLEGAL->colour changes are never transition errors.
- ILLEGAL sample: sets err_code, stores prev=ILLEGAL, clears armed, and does no transition or dwell check that cycle.
- Conflict: both decoded colours are in {GREEN, YELLOW} in the same sample, which sets err_conflict. ILLEGAL does not count as non-red for this check.
- Multiple errors in one cycle all set together; NS and WE are checked independently.
- Sticky flags hold until clear. cycle_done is a single-cycle pulse; cycle_count increments with it.

Decomposition:
- Shared package tl_pkg:
  - colour enum NONE/RED/YELLOW/GREEN/ILLEGAL;
  - lamp-code constants 100/010/001;
  - decode function.
- Sub-module tl_lamp_tracker, instantiated once per direction:
  - owns decode, prev colour, dwell counter and armed bit;
  - outputs colour, illegal_code, bad_trans, bad_dwell, and a rise_to_green strobe.
- Top-level tl_monitor: conflict check, sticky flags, cycle counter.

Test Plan:
1. clear 2 cycles, then 3 legal cycles (NS G30 Y5 R40 while WE R35 G30 Y5 R5, preceded by 5 all-red) -> all err_* stay 0; cycle_done pulses 3 times, one cycle each; cycle_count=3.
2. Armed run, NS yellow held 4 cycles then red -> err_dwell=1 at the edge sampling red; err_any=1; both stay high until clear.
3. NS GREEN while WE YELLOW for 1 sample -> err_conflict=1 at that edge; err_trans, err_code and err_dwell stay 0.
4. NS GREEN followed directly by RED -> err_trans=1; a following RED->GREEN produces a cycle_done pulse and no new error.
5. NS lamps 110 for 1 cycle, then GREEN 12 cycles, then YELLOW -> err_code=1; no err_dwell on the short green, because the segment after ILLEGAL is unarmed.
6. clear asserted mid-green for 1 cycle, then resume with green 10 more cycles -> all outputs 0 after the clear edge; the partial green is not flagged; cycle_count restarts at 0.
